// File: rtl/i2s_frame_sched.sv
// I2S transmit frame scheduler: frame counter, two-source pair arbitration, staging and load strobes.
// Build option: define I2S_FRAME_SCHED_HOLD_EN to repeat the previous pair on underrun instead of zeros.
module i2s_frame_sched #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned FRAME_LOG2 = 9,
  parameter int unsigned LOAD_OFS   = 7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  s0_valid,
  input  logic [BITS-1:0]       s0_left,
  input  logic [BITS-1:0]       s0_right,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [BITS-1:0]       s1_left,
  input  logic [BITS-1:0]       s1_right,
  output logic                  s1_ready,
  output logic [FRAME_LOG2-1:0] cyc,
  output logic                  frame_start,
  output logic                  ld,
  output logic                  ld_right,
  output logic [BITS-1:0]       ld_data,
  output logic                  running,
  output logic                  underrun,
  output logic [CNT_W-1:0]      urun_cnt,
  input  logic                  clr_stat
);

  localparam logic [FRAME_LOG2-1:0] Half = {1'b1, {(FRAME_LOG2-1){1'b0}}};
  localparam logic [FRAME_LOG2-1:0] LdL  = FRAME_LOG2'(LOAD_OFS);
  localparam logic [FRAME_LOG2-1:0] LdR  = LdL + Half;

  typedef enum logic [1:0] {StOff, StArm, StRun, StDrain} state_e;

  state_e                state_q;
  logic [FRAME_LOG2-1:0] cyc_q;
  logic                  stg_full_q;
  logic [BITS-1:0]       stg_l_q, stg_r_q, cur_l_q, cur_r_q;
  logic                  urun_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  ld_q, ld_right_q;
  logic [BITS-1:0]       ld_data_q;

  logic            boundary, open_win, xfer_live, urun_evt;
  logic            r0, r1, acc0, acc1, accept;
  logic [BITS-1:0] stg_l_d, stg_r_d;

  function automatic logic [BITS-1:0] sat_add(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS:0] s;
    s = {a[BITS-1], a} + {b[BITS-1], b};
    if (s[BITS] != s[BITS-1]) begin
      sat_add = s[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    end else begin
      sat_add = s[BITS-1:0];
    end
  endfunction

  assign boundary = &cyc_q;
  // Gated on en as well: a pair taken while leaving ARM/RUN would only be discarded.
  assign open_win = !stg_full_q && !boundary && en &&
                    ((state_q == StArm) || (state_q == StRun));
  assign xfer_live = (state_q == StRun) || ((state_q == StArm) && en);
  assign urun_evt  = boundary && xfer_live && !stg_full_q;

  always_comb begin
    r0 = 1'b0;
    r1 = 1'b0;
    unique case (mode)
      2'b00: r0 = open_win;
      2'b01: r1 = open_win;
      2'b10: begin
        r0 = open_win;
        r1 = open_win && !s0_valid;
      end
      2'b11: begin
        r0 = open_win && s0_valid && s1_valid;
        r1 = open_win && s0_valid && s1_valid;
      end
    endcase
  end

  assign s0_ready = r0;
  assign s1_ready = r1;
  assign acc0     = s0_valid && r0;
  assign acc1     = s1_valid && r1;
  assign accept   = acc0 || acc1;

  always_comb begin
    stg_l_d = s1_left;
    stg_r_d = s1_right;
    if (mode == 2'b11) begin
      stg_l_d = sat_add(s0_left, s1_left);
      stg_r_d = sat_add(s0_right, s1_right);
    end else if (acc0) begin
      stg_l_d = s0_left;
      stg_r_d = s0_right;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StOff;
    end else begin
      case (state_q)
        StOff:   if (en) state_q <= StArm;
        StArm:   if (!en) state_q <= StOff; else if (boundary) state_q <= StRun;
        StRun:   if (!en) state_q <= StDrain;
        StDrain: if (boundary) state_q <= StOff;
        default: state_q <= StOff;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stg_full_q <= 1'b0;
      stg_l_q    <= '0;
      stg_r_q    <= '0;
    end else if (boundary || ((state_q == StArm) && !en)) begin
      stg_full_q <= 1'b0;
    end else if (accept) begin
      stg_full_q <= 1'b1;
      stg_l_q    <= stg_l_d;
      stg_r_q    <= stg_r_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cur_l_q <= '0;
      cur_r_q <= '0;
    end else if (boundary) begin
      if (xfer_live && stg_full_q) begin
        cur_l_q <= stg_l_q;
        cur_r_q <= stg_r_q;
      end else if (!xfer_live) begin
        cur_l_q <= '0;
        cur_r_q <= '0;
      end else begin
`ifdef I2S_FRAME_SCHED_HOLD_EN
        cur_l_q <= cur_l_q;
        cur_r_q <= cur_r_q;
`else
        cur_l_q <= '0;
        cur_r_q <= '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      urun_q <= 1'b0;
      cnt_q  <= '0;
    end else if (clr_stat) begin
      urun_q <= 1'b0;
      cnt_q  <= '0;
    end else if (urun_evt) begin
      urun_q <= 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ld_q       <= 1'b0;
      ld_right_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      ld_q       <= (cyc_q == LdL) || (cyc_q == LdR);
      ld_right_q <= (cyc_q == LdR);
      if (cyc_q == LdL) begin
        ld_data_q <= cur_l_q;
      end else if (cyc_q == LdR) begin
        ld_data_q <= cur_r_q;
      end
    end
  end

  assign cyc         = cyc_q;
  assign frame_start = (cyc_q == '0);
  assign ld          = ld_q;
  assign ld_right    = ld_right_q;
  assign ld_data     = ld_data_q;
  assign running     = (state_q == StRun);
  assign underrun    = urun_q;
  assign urun_cnt    = cnt_q;

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Scoreboard bench for i2s_frame_sched: per-frame expected pairs queued by stimulus, checked on ld.
module tb_i2s_frame_sched;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [31:0] s0_left = '0, s0_right = '0, s1_left = '0, s1_right = '0;
  logic        s0_ready, s1_ready;
  logic [8:0]  cyc;
  logic        frame_start, ld, ld_right, running, underrun;
  logic [31:0] ld_data;
  logic [15:0] urun_cnt;
  logic        clr_stat = 1'b0;

  i2s_frame_sched dut (
    .clk(clk), .nrst(nrst), .en(en), .mode(mode),
    .s0_valid(s0_valid), .s0_left(s0_left), .s0_right(s0_right), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_left(s1_left), .s1_right(s1_right), .s1_ready(s1_ready),
    .cyc(cyc), .frame_start(frame_start), .ld(ld), .ld_right(ld_right), .ld_data(ld_data),
    .running(running), .underrun(underrun), .urun_cnt(urun_cnt), .clr_stat(clr_stat)
  );

  always #20 clk = ~clk;

`ifdef I2S_FRAME_SCHED_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic [8:0] tb_cyc;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 9'd1;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_l[$];
  logic [31:0] exp_r[$];
  logic [31:0] last_l = '0, last_r = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: ld words compared against the queued per-frame expectation.
  always @(negedge clk) begin : mon
    logic        is_r;
    logic [31:0] want;
    if (nrst) begin
      if (tb_cyc == 9'd0) begin
        check_eq("cyc_wrap", 32'(cyc), 32'd0);
        check_eq("frame_start", 32'(frame_start), 32'd1);
      end
      if (tb_cyc == 9'd8 || tb_cyc == 9'd264) begin
        is_r = (tb_cyc == 9'd264);
        check_eq("ld_pulse", 32'(ld), 32'd1);
        check_eq("ld_right", 32'(ld_right), 32'(is_r));
        if (exp_l.size() == 0) begin
          check_eq("sb_nonempty", 32'(exp_l.size() != 0), 32'd1);
        end else begin
          want = is_r ? exp_r[0] : exp_l[0];
          check_eq(is_r ? "ld_data_r" : "ld_data_l", ld_data, want);
          if (is_r) begin
            void'(exp_l.pop_front());
            void'(exp_r.pop_front());
          end
        end
      end
      if (tb_cyc == 9'd9 || tb_cyc == 9'd265) check_eq("ld_width", 32'(ld), 32'd0);
    end
  end

  task automatic go_to(input int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (32'(tb_cyc) != c && n < 1024);
    if (n >= 1024) check_eq("go_to_timeout", 32'(tb_cyc), 32'(c));
  endtask

  task automatic expect_next(input logic [31:0] l, input logic [31:0] r);
    go_to(505);
    exp_l.push_back(l);
    exp_r.push_back(r);
    last_l = l;
    last_r = r;
  endtask

  task automatic expect_urun();
    if (Hold) expect_next(last_l, last_r);
    else      expect_next(32'h0, 32'h0);
  endtask

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_cyc", 32'(cyc), 32'd0);
    check_eq("rst_ld", 32'(ld), 32'd0);
    check_eq("rst_ld_data", ld_data, 32'd0);
    check_eq("rst_s0_ready", 32'(s0_ready), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_urun_cnt", 32'(urun_cnt), 32'd0);
    check_eq("rst_frame_start", 32'(frame_start), 32'd1);
    exp_l.push_back('0);
    exp_r.push_back('0);
    @(posedge clk);
    #2 nrst = 1'b1;

    // Frames 0-1: disabled, offers ignored, zero words
    go_to(100);
    s0_valid = 1'b1; s1_valid = 1'b1;
    #1;
    check_eq("off_s0_ready", 32'(s0_ready), 32'd0);
    check_eq("off_s1_ready", 32'(s1_ready), 32'd0);
    go_to(101);
    s0_valid = 1'b0; s1_valid = 1'b0;
    check_eq("off_running", 32'(running), 32'd0);
    expect_next(32'h0, 32'h0);
    expect_next(32'h0, 32'h0);

    // Frame 2: enable, src0 pair at cyc 100 (mode 00 ignores src1)
    go_to(50);
    en = 1'b1; mode = 2'b00;
    go_to(100);
    s0_valid = 1'b1; s0_left = 32'h12345678; s0_right = 32'h9ABCDEF0;
    s1_valid = 1'b1; s1_left = 32'hDEADBEEF; s1_right = 32'hDEADBEEF;
    #1;
    check_eq("m00_s0_ready", 32'(s0_ready), 32'd1);
    check_eq("m00_s1_ready", 32'(s1_ready), 32'd0);
    go_to(101);
    s0_valid = 1'b0; s1_valid = 1'b0;
    check_eq("arm_running", 32'(running), 32'd0);
    expect_next(32'h12345678, 32'h9ABCDEF0);

    // Frame 3: mode 10 with both valid, src0 wins
    go_to(5);
    mode = 2'b10;
    go_to(10);
    check_eq("run_running", 32'(running), 32'd1);
    check_eq("run_urun_cnt", 32'(urun_cnt), 32'd0);
    go_to(100);
    s0_valid = 1'b1; s0_left = 32'h11111111; s0_right = 32'h22222222;
    s1_valid = 1'b1; s1_left = 32'h33333333; s1_right = 32'h44444444;
    #1;
    check_eq("m10_s0_ready", 32'(s0_ready), 32'd1);
    check_eq("m10_s1_ready", 32'(s1_ready), 32'd0);
    go_to(101);
    s0_valid = 1'b0; s1_valid = 1'b0;
    expect_next(32'h11111111, 32'h22222222);

    // Frame 4: mode 10 fallback to src1
    go_to(100);
    s1_valid = 1'b1; s1_left = 32'h55555555; s1_right = 32'h66666666;
    #1;
    check_eq("m10_fallback_s1_ready", 32'(s1_ready), 32'd1);
    go_to(101);
    s1_valid = 1'b0;
    expect_next(32'h55555555, 32'h66666666);

    // Frame 5: saturating mix, needs both valid
    go_to(5);
    mode = 2'b11;
    go_to(90);
    s0_valid = 1'b1; s0_left = 32'h7FFFFFF0; s0_right = 32'h80000001;
    s1_left = 32'h00000100; s1_right = 32'hFFFFFF00;
    #1;
    check_eq("m11_lone_s0_ready", 32'(s0_ready), 32'd0);
    go_to(100);
    s1_valid = 1'b1;
    #1;
    check_eq("m11_s0_ready", 32'(s0_ready), 32'd1);
    check_eq("m11_s1_ready", 32'(s1_ready), 32'd1);
    go_to(101);
    s0_valid = 1'b0; s1_valid = 1'b0;
    expect_next(32'h7FFFFFFF, 32'h80000000);

    // Frames 6-8: starved, three underruns
    go_to(10);
    check_eq("pre_urun_cnt", 32'(urun_cnt), 32'd0);
    expect_urun();
    expect_urun();
    expect_urun();

    // Frame 9: stats, then boundary offer plus clear racing an underrun
    go_to(10);
    check_eq("urun_cnt3", 32'(urun_cnt), 32'd3);
    check_eq("underrun_flag", 32'(underrun), 32'd1);
    mode = 2'b00;
    expect_urun();
    go_to(511);
    s0_valid = 1'b1; s0_left = 32'h0BADF00D; s0_right = 32'hCAFEBABE;
    clr_stat = 1'b1;
    #1;
    check_eq("boundary_no_ready", 32'(s0_ready), 32'd0);
    go_to(0);
    clr_stat = 1'b0;
    #1;
    check_eq("post_boundary_ready", 32'(s0_ready), 32'd1);
    go_to(1);
    s0_valid = 1'b0;
    go_to(5);
    check_eq("clr_urun_cnt", 32'(urun_cnt), 32'd0);
    check_eq("clr_underrun", 32'(underrun), 32'd0);
    expect_next(32'h0BADF00D, 32'hCAFEBABE);

    // Frame 11: drop en mid-frame, drain to OFF
    go_to(150);
    en = 1'b0;
    go_to(151);
    check_eq("drain_running", 32'(running), 32'd0);
    expect_next(32'h0, 32'h0);

    // Frame 12: re-arm with a staged pair, then reset mid-frame
    go_to(5);
    check_eq("drain_no_urun", 32'(urun_cnt), 32'd0);
    go_to(20);
    en = 1'b1;
    go_to(50);
    s0_valid = 1'b1; s0_left = 32'hA5A5A5A5; s0_right = 32'h5A5A5A5A;
    #1;
    check_eq("rearm_ready", 32'(s0_ready), 32'd1);
    go_to(51);
    s0_valid = 1'b0;
    go_to(300);
    nrst = 1'b0;
    s0_valid = 1'b1;
    #1;
    check_eq("mid_rst_cyc", 32'(cyc), 32'd0);
    check_eq("mid_rst_ld", 32'(ld), 32'd0);
    check_eq("mid_rst_ld_right", 32'(ld_right), 32'd0);
    check_eq("mid_rst_ld_data", ld_data, 32'd0);
    check_eq("mid_rst_running", 32'(running), 32'd0);
    check_eq("mid_rst_s0_ready", 32'(s0_ready), 32'd0);
    check_eq("mid_rst_frame_start", 32'(frame_start), 32'd1);
    s0_valid = 1'b0;
    en = 1'b0;
    exp_l.delete();
    exp_r.delete();
    exp_l.push_back('0);
    exp_r.push_back('0);
    last_l = '0;
    last_r = '0;
    repeat (2) @(posedge clk);
    #2 nrst = 1'b1;
    expect_next(32'h0, 32'h0);
    go_to(300);
    check_eq("sb_drained", 32'(exp_l.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
